// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    localparam int unsigned MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Number of serial bits per frame: data bits plus optional parity bit.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned parity_en);
        return data_w + ((parity_en != 0) ? 1 : 0);
    endfunction

    // Bit counter width able to hold 0..flen-1.
    function automatic int unsigned cnt_width(input int unsigned flen);
        return (flen < 3) ? 1 : $clog2(flen);
    endfunction

    // Even parity is the XOR of the data; odd parity is its complement.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with one-word holding register,
// configurable bit order, optional parity and registered frame markers.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_W, PARITY_EN);
    localparam int unsigned CNT_W     = cnt_width(FRAME_LEN);

    localparam logic [CNT_W-1:0] LAST_DATA_IDX  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_FRAME_IDX = CNT_W'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                hold_full_q, hold_full_d;

    logic                sout_d, sval_d, fs_d, fe_d, busy_d;

    logic                last_bit_c;
    logic                load_c;
    logic                accept_c;
    logic                do_start_c;
    logic                hold_first_c;
    logic                shift_next_c;
    logic [DATA_W-1:0]   hold_shifted_c;
    logic [DATA_W-1:0]   shift_shifted_c;

    // Frame-boundary and handshake decode from registered state.
    always_comb begin
        last_bit_c = ((state_q == ST_DATA) && (cnt_q == LAST_DATA_IDX) && (PARITY_EN == 0))
                   || (state_q == ST_PARITY);
        load_c     = !flush && hold_full_q && ((state_q == ST_IDLE) || last_bit_c);
        in_ready   = !flush && (!hold_full_q || load_c);
        accept_c   = in_valid && in_ready;
    end

    // Bit selection and shift direction for the configured bit order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            hold_first_c    = hold_data_q[DATA_W-1];
            shift_next_c    = shift_q[DATA_W-1];
            hold_shifted_c  = {hold_data_q[DATA_W-2:0], 1'b0};
            shift_shifted_c = {shift_q[DATA_W-2:0], 1'b0};
        end else begin
            hold_first_c    = hold_data_q[0];
            shift_next_c    = shift_q[0];
            hold_shifted_c  = {1'b0, hold_data_q[DATA_W-1:1]};
            shift_shifted_c = {1'b0, shift_q[DATA_W-1:1]};
        end
    end

    // Next-state logic for holding register, engine FSM and serial outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        sout_d      = 1'b0;
        sval_d      = 1'b0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        do_start_c  = 1'b0;

        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end else begin
            if (accept_c) begin
                hold_full_d = 1'b1;
                hold_data_d = in_data;
            end else if (load_c) begin
                hold_full_d = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    do_start_c = load_c;
                end
                ST_DATA: begin
                    if (cnt_q == LAST_DATA_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            cnt_d   = cnt_q + CNT_W'(1);
                            sout_d  = par_q;
                            sval_d  = 1'b1;
                            fe_d    = 1'b1;
                        end else if (load_c) begin
                            do_start_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        shift_d = shift_shifted_c;
                        sout_d  = shift_next_c;
                        sval_d  = 1'b1;
                        fe_d    = ((cnt_q + CNT_W'(1)) == LAST_FRAME_IDX);
                    end
                end
                ST_PARITY: begin
                    if (load_c) begin
                        do_start_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Start a new frame from the held word with no idle gap.
            if (do_start_c) begin
                state_d = ST_DATA;
                cnt_d   = '0;
                shift_d = hold_shifted_c;
                par_d   = parity_bit(MAX_DATA_W'(hold_data_q), 1'(PARITY_ODD));
                sout_d  = hold_first_c;
                sval_d  = 1'b1;
                fs_d    = 1'b1;
            end
        end

        busy_d = hold_full_d || (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            hold_data_q  <= '0;
            hold_full_q  <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_data_q  <= hold_data_d;
            hold_full_q  <= hold_full_d;
            serial_out   <= sout_d;
            serial_valid <= sval_d;
            frame_start  <= fs_d;
            frame_end    <= fe_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four configurations, directed vector table,
// hand-written multi-cycle sequences and a randomized scoreboard run.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        flush        [4];
    logic        in_valid     [4];
    logic [31:0] in_data      [4];
    logic        in_ready     [4];
    logic        serial_out   [4];
    logic        serial_valid [4];
    logic        frame_start  [4];
    logic        frame_end    [4];
    logic        busy         [4];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    piso_serializer #(.DATA_W(10), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .reset_n(reset_n), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0][9:0]), .serial_out(serial_out[0]),
        .serial_valid(serial_valid[0]), .frame_start(frame_start[0]),
        .frame_end(frame_end[0]), .busy(busy[0]));

    piso_serializer #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset_n(reset_n), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1][7:0]), .serial_out(serial_out[1]),
        .serial_valid(serial_valid[1]), .frame_start(frame_start[1]),
        .frame_end(frame_end[1]), .busy(busy[1]));

    piso_serializer #(.DATA_W(10), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u2 (
        .clk(clk), .reset_n(reset_n), .flush(flush[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_data(in_data[2][9:0]), .serial_out(serial_out[2]),
        .serial_valid(serial_valid[2]), .frame_start(frame_start[2]),
        .frame_end(frame_end[2]), .busy(busy[2]));

    piso_serializer #(.DATA_W(10), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .reset_n(reset_n), .flush(flush[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .in_data(in_data[3][9:0]), .serial_out(serial_out[3]),
        .serial_valid(serial_valid[3]), .frame_start(frame_start[3]),
        .frame_end(frame_end[3]), .busy(busy[3]));

    // Configuration of each instance.
    function automatic int cfg_dw(input int d);
        return (d == 1) ? 8 : 10;
    endfunction
    function automatic bit cfg_msb(input int d);
        return d != 1;
    endfunction
    function automatic bit cfg_pen(input int d);
        return d >= 2;
    endfunction
    function automatic bit cfg_podd(input int d);
        return d == 3;
    endfunction
    function automatic int cfg_flen(input int d);
        return cfg_dw(d) + (cfg_pen(d) ? 1 : 0);
    endfunction

    // i-th transmitted bit of a frame, straight from the bit-order/parity rules.
    function automatic logic ref_bit(input int d, input logic [31:0] word, input int i);
        int dw;
        dw = cfg_dw(d);
        if (i < dw) return cfg_msb(d) ? word[dw-1-i] : word[i];
        return logic'(($countones(word) % 2) == 1) ^ cfg_podd(d);
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 4; d++) begin
            flush[d]    = 1'b0;
            in_valid[d] = 1'b0;
            in_data[d]  = '0;
        end
    endtask

    // Advance one clock; returns at the following falling edge.
    task automatic adv();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_outs(input string name, input int d, input logic sv, input logic so,
                              input logic fs, input logic fe, input logic bz);
        check({name, "_valid"}, d, 32'(serial_valid[d]), 32'(sv));
        check({name, "_out"},   d, 32'(serial_out[d]),   32'(so));
        check({name, "_fs"},    d, 32'(frame_start[d]),  32'(fs));
        check({name, "_fe"},    d, 32'(frame_end[d]),    32'(fe));
        check({name, "_busy"},  d, 32'(busy[d]),         32'(bz));
    endtask

    // Send one word from idle and check the whole frame against a literal bit sequence.
    task automatic run_vec(input int d, input logic [31:0] word, input logic [63:0] seq,
                           input int len);
        in_valid[d] = 1'b1;
        in_data[d]  = word;
        #1;
        check("vec_ready", d, 32'(in_ready[d]), 32'd1);
        adv();
        in_valid[d] = 1'b0;
        check_outs("vec_hold", d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= len; i++) begin
            adv();
            check_outs("vec_bit", d, 1'b1, seq[len-i], i == 1, i == len, 1'b1);
        end
        adv();
        check_outs("vec_after", d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int          d;
        logic [31:0] word;
        logic [63:0] seq;
        int          len;
    } vec_t;

    // Scoreboard: expected serial bits tagged with the edge they must appear on.
    typedef struct {
        int   edge_n;
        logic b;
        logic fs;
        logic fe;
    } ev_t;

    ev_t evq[$];
    int  startq[$];
    int  last_end;

    task automatic push_frame(input int d, input logic [31:0] word, input int acc_edge);
        int st;
        int fl;
        fl = cfg_flen(d);
        st = (last_end + 1 > acc_edge + 1) ? last_end + 1 : acc_edge + 1;
        for (int i = 0; i < fl; i++) evq.push_back('{st + i, ref_bit(d, word, i), i == 0, i == fl - 1});
        startq.push_back(st);
        last_end = st + fl - 1;
    endtask

    task automatic rand_cycle(input int d, input logic v, input logic fl, input logic [31:0] w);
        logic exp_rdy;
        logic acc;
        ev_t  e;
        logic ev_hit;
        flush[d]    = fl;
        in_valid[d] = v;
        in_data[d]  = w;
        #1;
        while (startq.size() > 0 && startq[0] <= cyc) void'(startq.pop_front());
        exp_rdy = !fl && (startq.size() == 0 || (startq.size() == 1 && startq[0] == cyc + 1));
        check("rnd_ready", d, 32'(in_ready[d]), 32'(exp_rdy));
        acc = v && in_ready[d] && !fl;
        @(posedge clk);
        cyc++;
        if (fl) begin
            evq.delete();
            startq.delete();
            last_end = cyc;
        end else if (acc) begin
            push_frame(d, w, cyc);
        end
        @(negedge clk);
        while (startq.size() > 0 && startq[0] <= cyc) void'(startq.pop_front());
        ev_hit = 1'b0;
        e      = '{0, 1'b0, 1'b0, 1'b0};
        if (evq.size() > 0 && evq[0].edge_n == cyc) begin
            e      = evq.pop_front();
            ev_hit = 1'b1;
        end
        check_outs("rnd", d, ev_hit, e.b, e.fs, e.fe, ev_hit || (startq.size() > 0));
    endtask

    task automatic rand_test(input int d, input int n);
        logic [31:0] mask;
        mask = (32'd1 << cfg_dw(d)) - 32'd1;
        evq.delete();
        startq.delete();
        last_end = cyc;
        for (int k = 0; k < n; k++)
            rand_cycle(d, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom() & mask);
        for (int k = 0; k < 2 * cfg_flen(d) + 2; k++) rand_cycle(d, 1'b0, 1'b0, 32'd0);
        idle_all();
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] wa, wb;
        idle_all();
        reset_n = 1'b0;

        vecs.push_back('{0, 32'(10'b1011001110), 64'b1011001110,  10});
        vecs.push_back('{0, 32'(10'b1000000001), 64'b1000000001,  10});
        vecs.push_back('{1, 32'h0A5,             64'b10100101,    8});
        vecs.push_back('{1, 32'h0C1,             64'b10000011,    8});
        vecs.push_back('{2, 32'h3FF,             64'b11111111110, 11});
        vecs.push_back('{2, 32'h001,             64'b00000000011, 11});
        vecs.push_back('{3, 32'h001,             64'b00000000010, 11});
        vecs.push_back('{3, 32'h000,             64'b00000000001, 11});

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_outs("rst", d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) check("rst_ready", d, 32'(in_ready[d]), 32'd1);
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) run_vec(vecs[i].d, vecs[i].word, vecs[i].seq, vecs[i].len);

        // Back-to-back words: 20 contiguous bits, in_ready low until second word loads.
        wa = 32'h2B5;
        wb = 32'h14A;
        in_valid[0] = 1'b1;
        in_data[0]  = wa;
        adv();
        #1;
        check("b2b_ready_load", 0, 32'(in_ready[0]), 32'd1);
        in_data[0] = wb;
        for (int k = 1; k <= 20; k++) begin
            adv();
            in_valid[0] = 1'b0;
            #1;
            check_outs("b2b", 0, 1'b1, (k <= 10) ? wa[10-k] : wb[20-k],
                       k == 1 || k == 11, k == 10 || k == 20, 1'b1);
            check("b2b_ready", 0, 32'(in_ready[0]), 32'(k >= 10));
        end
        adv();
        check_outs("b2b_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush on the 4th bit with a second word held.
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h3FF;
        adv();
        in_data[0] = 32'h3FF;
        adv();
        in_valid[0] = 1'b0;
        adv();
        adv();
        adv();
        check_outs("pre_flush", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h155;
        #1;
        check("flush_ready", 0, 32'(in_ready[0]), 32'd0);
        adv();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        check_outs("flush", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_ready_after", 0, 32'(in_ready[0]), 32'd1);
        for (int k = 0; k < 24; k++) begin
            adv();
            check_outs("flush_quiet", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-frame, then a clean frame.
        in_valid[2] = 1'b1;
        in_data[2]  = 32'h2C3;
        adv();
        in_valid[2] = 1'b0;
        for (int k = 0; k < 5; k++) adv();
        check("pre_rst_valid", 2, 32'(serial_valid[2]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_rst", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("async_rst_hold", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 2, 32'(in_ready[2]), 32'd1);
        run_vec(2, 32'h2C3, 64'b10110000111, 11);

        // Randomized traffic against the scoreboard on every configuration.
        for (int d = 0; d < 4; d++) rand_test(d, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
